// File: rtl/s2p_weight_packer.sv
// s2p_weight_packer: packs narrow DMA beats into wide weight-memory words.
// Two ping-pong buffers let the DMA keep streaming while the previous word
// drains under memory backpressure. Addresses auto-increment from a base, a
// programmed word count ends the job with a done pulse, and a flush pads a
// partial word with zeros.
module s2p_weight_packer #(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned OUT_W  = 1024,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned CNT_W  = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // DMA write slave
  input  logic                 s_chipselect,
  input  logic                 s_write_n,
  input  logic [IN_W-1:0]      s_writedata,
  output logic                 s_waitrequest,
  // job control
  input  logic                 cfg_start,
  input  logic [ADDR_W-1:0]    cfg_base_addr,
  input  logic [CNT_W-1:0]     cfg_words,
  input  logic                 cfg_flush,
  output logic                 busy,
  output logic                 done,
  // weight-memory write master
  output logic [OUT_W-1:0]     m_writedata,
  output logic [ADDR_W-1:0]    m_address,
  output logic                 m_write,
  output logic [OUT_W/8-1:0]   m_byteenable,
  input  logic                 m_waitrequest
);

  localparam int unsigned BEATS = OUT_W / IN_W;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic {M_IDLE, M_WR} mstate_e;

  mstate_e             state_q, state_d;
  logic                fill_q, fill_d;
  logic                drain_q, drain_d;
  logic [1:0]          full_q, full_d;
  logic [CW-1:0]       beat_q, beat_d;
  logic [CNT_W-1:0]    words_q, words_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                swait_q, swait_d;
  logic                mwrite_q, mwrite_d;
  logic [OUT_W-1:0]    mdata_q, mdata_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [OUT_W-1:0]    buf_q [2];
  logic [OUT_W-1:0]    buf_d [2];
  logic                accept_c;

  assign accept_c = s_chipselect & ~s_write_n & ~swait_q;

  // Next-state: beat packing, flush, master FSM and job control.
  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    drain_d  = drain_q;
    full_d   = full_q;
    beat_d   = beat_q;
    words_d  = words_q;
    addr_d   = addr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mwrite_d = mwrite_q;
    mdata_d  = mdata_q;
    maddr_d  = maddr_q;
    buf_d    = buf_q;

    if (busy_q) begin
      // Beat 0 clears the buffer so a flushed partial word is already zero-padded.
      if (accept_c) begin
        if (beat_q == '0) buf_d[fill_q] = '0;
        for (int unsigned k = 0; k < BEATS; k++) begin
          if (beat_q == CW'(k)) buf_d[fill_q][k*IN_W +: IN_W] = s_writedata;
        end
        if (beat_q == LAST_BEAT) begin
          full_d[fill_q] = 1'b1;
          fill_d         = ~fill_q;
          beat_d         = '0;
        end else begin
          beat_d = beat_q + CW'(1);
        end
      end

      // Flush only acts on a word that is still partially filled.
      if (cfg_flush && (beat_d != '0)) begin
        full_d[fill_q] = 1'b1;
        fill_d         = ~fill_q;
        beat_d         = '0;
      end

      case (state_q)
        M_IDLE: begin
          if (full_d[drain_q]) begin
            state_d  = M_WR;
            mwrite_d = 1'b1;
            mdata_d  = buf_d[drain_q];
            maddr_d  = addr_q;
          end
        end
        M_WR: begin
          if (!m_waitrequest) begin
            full_d[drain_q] = 1'b0;
            drain_d         = ~drain_q;
            addr_d          = addr_q + ADDR_W'(1);
            words_d         = words_q - CNT_W'(1);
            if (words_q == CNT_W'(1)) begin
              // Last word of the job: anything buffered beyond it is dropped.
              busy_d   = 1'b0;
              done_d   = 1'b1;
              state_d  = M_IDLE;
              mwrite_d = 1'b0;
              full_d   = '0;
              beat_d   = '0;
            end else if (full_d[~drain_q]) begin
              mdata_d = buf_d[~drain_q];
              maddr_d = addr_q + ADDR_W'(1);
            end else begin
              state_d  = M_IDLE;
              mwrite_d = 1'b0;
            end
          end
        end
        default: state_d = M_IDLE;
      endcase
    end else if (cfg_start) begin
      addr_d  = cfg_base_addr;
      words_d = cfg_words;
      beat_d  = '0;
      fill_d  = 1'b0;
      drain_d = 1'b0;
      full_d  = '0;
      busy_d  = 1'b1;
      state_d = M_IDLE;
    end

    swait_d = ~busy_d | full_d[fill_d];
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= M_IDLE;
      fill_q   <= 1'b0;
      drain_q  <= 1'b0;
      full_q   <= '0;
      beat_q   <= '0;
      words_q  <= '0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      swait_q  <= 1'b1;
      mwrite_q <= 1'b0;
      mdata_q  <= '0;
      maddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      fill_q   <= fill_d;
      drain_q  <= drain_d;
      full_q   <= full_d;
      beat_q   <= beat_d;
      words_q  <= words_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      swait_q  <= swait_d;
      mwrite_q <= mwrite_d;
      mdata_q  <= mdata_d;
      maddr_q  <= maddr_d;
    end
  end

  // Buffer storage needs no reset; contents are only read once marked full.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign s_waitrequest = swait_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign m_write       = mwrite_q;
  assign m_writedata   = mdata_q;
  assign m_address     = maddr_q;
  assign m_byteenable  = '1;

endmodule
